pwl_coef_loader: RTL and testbench
==================================

PWL_COEF_LOADER -- requirements
Module: pwl_coef_loader

Interface
REQ-001 SHALL have parameter U, default 8: table index width; table depth 1<<U entries.
REQ-002 SHALL have parameter K_WIDTH, default 16: slope k word width, signed fixed-point, stored opaque.
REQ-003 SHALL have parameter B_WIDTH, default 16: intercept b word width, stored opaque.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-006 SHALL have port start, input, 1: single-cycle load request.
REQ-007 SHALL have port in_valid, input, 1: in_data valid.
REQ-008 SHALL have port in_data, input, max(K_WIDTH,B_WIDTH): coefficient word, LSB-aligned.
REQ-009 SHALL have port in_ready, output, 1: loader accepts a word this cycle.
REQ-010 SHALL have port wr_en, output, 1: table write strobe.
REQ-011 SHALL have port wr_addr, output, U: table entry index.
REQ-012 SHALL have port wr_data, output, K_WIDTH+B_WIDTH: entry packed {k,b}, k in MSBs, same packing the PWL evaluator table uses.
REQ-013 SHALL have port busy, output, 1: load in progress.
REQ-014 SHALL have port done, output, 1: full table written.
REQ-015 SHALL have port cksum_err, output, 1: checksum mismatch (see Configuration).

Function
REQ-016 SHALL use states IDLE, GET_K, GET_B, WRITE, CHECK, DONE.
REQ-017 SHALL transfer a word only when in_valid and in_ready are both high at a clock edge.
REQ-018 SHALL, in IDLE or DONE, on start go to GET_K, clear entry counter to 0, clear done and cksum_err.
REQ-019 SHALL ignore start while busy.
REQ-020 SHALL assert in_ready only in GET_K, GET_B, CHECK; deassert it in all other states.
REQ-021 SHALL in GET_K capture in_data[K_WIDTH-1:0] as k on transfer, go to GET_B.
REQ-022 SHALL in GET_B capture in_data[B_WIDTH-1:0] as b on transfer, go to WRITE.
REQ-023 SHALL in WRITE assert wr_en for exactly one cycle with wr_addr = entry counter, wr_data = {k,b}.
REQ-024 SHALL after WRITE increment the counter and go to GET_K unless counter was (1<<U)-1, then go to CHECK (macro defined) or DONE (macro undefined).
REQ-025 SHALL hold wr_en low outside WRITE; wr_addr and wr_data are don't-care when wr_en low.
REQ-026 SHALL produce minimum 3 cycles per entry (k, b, write) with in_valid held high; stalls on in_valid low extend GET_K/GET_B without limit.
REQ-027 SHALL assert busy in GET_K, GET_B, WRITE, CHECK.
REQ-028 SHALL assert done continuously in DONE until next accepted start or rst.
REQ-029 SHALL never let the counter wrap; exactly 1<<U writes per load, addresses 0..(1<<U)-1 ascending.

Reset
REQ-030 SHALL on rst go to IDLE; busy, done, wr_en, in_ready, cksum_err = 0; counter = 0.
REQ-031 SHALL on rst mid-load abandon the load with no further writes; entries already written remain in the table.
REQ-032 SHALL give rst priority over start and over any same-cycle transfer.

Configuration
REQ-033 SHALL with macro PWL_LOADER_CKSUM_EN defined keep a 16-bit modular sum of all accepted k and b words (zero-extended/truncated to 16 bits), cleared on start.
REQ-034 SHALL with PWL_LOADER_CKSUM_EN defined, in CHECK accept one extra word, set cksum_err if in_data[15:0] != sum, then go to DONE; done asserts regardless of cksum_err.
REQ-035 SHALL with PWL_LOADER_CKSUM_EN undefined omit sum logic and CHECK, tie cksum_err to 0, go WRITE->DONE after last entry.

Verification
REQ-036 U=2, start, stream k/b = 0x0001/0x0010, 0x0002/0x0020, 0x0003/0x0030, 0x0004/0x0040 with in_valid always high -> 4 writes, wr_data 0x00010010..0x00040040 at wr_addr 0..3, 3 cycles apart; done after last.
REQ-037 Same stream with in_valid low 2 cycles between every word -> identical writes and data, only later; no extra wr_en.
REQ-038 start pulsed while busy after entry 1 -> ignored; counter continues, total 4 writes.
REQ-039 rst asserted after second write -> wr_en never high again, busy=0, done=0; new start reloads from addr 0.
REQ-040 PWL_LOADER_CKSUM_EN defined, REQ-036 stream then 0x00AA -> cksum_err=0, done=1; then 0x00AB -> cksum_err=1, done=1.

Source files
------------

// File: rtl/pwl_coef_loader.sv
// rtl/pwl_coef_loader.sv - streams k/b coefficient pairs into a PWL evaluator table.
// Optional checksum word after the table: enable with `define PWL_LOADER_CKSUM_EN.
module pwl_coef_loader #(
  parameter int U       = 8,
  parameter int K_WIDTH = 16,
  parameter int B_WIDTH = 16
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 start,
  input  logic                                                 in_valid,
  input  logic [((K_WIDTH > B_WIDTH) ? K_WIDTH : B_WIDTH)-1:0] in_data,
  output logic                                                 in_ready,
  output logic                                                 wr_en,
  output logic [U-1:0]                                         wr_addr,
  output logic [K_WIDTH+B_WIDTH-1:0]                           wr_data,
  output logic                                                 busy,
  output logic                                                 done,
  output logic                                                 cksum_err
);

  localparam int DW = (K_WIDTH > B_WIDTH) ? K_WIDTH : B_WIDTH;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GET_K = 3'd1,
    GET_B = 3'd2,
    WRITE = 3'd3,
`ifdef PWL_LOADER_CKSUM_EN
    CHECK = 3'd4,
`endif
    DONE  = 3'd5
  } state_t;

  state_t               state, state_nx;
  logic [U-1:0]         cnt;
  logic [K_WIDTH-1:0]   k_reg;
  logic [B_WIDTH-1:0]   b_reg;
  logic                 xfer;
  logic                 cnt_last;
  logic                 start_ok;

  assign xfer     = in_valid && in_ready;
  assign cnt_last = (cnt == {U{1'b1}});
  // start is only honoured when no load is running
  assign start_ok = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = GET_K;
      GET_K:      if (in_valid) state_nx = GET_B;
      GET_B:      if (in_valid) state_nx = WRITE;
      WRITE: begin
        if (!cnt_last) begin
          state_nx = GET_K;
        end else begin
`ifdef PWL_LOADER_CKSUM_EN
          state_nx = CHECK;
`else
          state_nx = DONE;
`endif
        end
      end
`ifdef PWL_LOADER_CKSUM_EN
      CHECK:      if (in_valid) state_nx = DONE;
`endif
      default:    state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    case (state)
      GET_K, GET_B: in_ready = 1'b1;
`ifdef PWL_LOADER_CKSUM_EN
      CHECK:        in_ready = 1'b1;
`endif
      default:      in_ready = 1'b0;
    endcase
  end

  assign wr_en   = (state == WRITE);
  assign wr_addr = cnt;
  assign wr_data = {k_reg, b_reg};
  assign busy    = (state != IDLE) && (state != DONE);
  assign done    = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      k_reg <= '0;
      b_reg <= '0;
    end else begin
      state <= state_nx;
      if (start_ok) cnt <= '0;
      if ((state == GET_K) && xfer) k_reg <= in_data[K_WIDTH-1:0];
      if ((state == GET_B) && xfer) b_reg <= in_data[B_WIDTH-1:0];
      // hold at the last index so the counter can never wrap
      if ((state == WRITE) && !cnt_last) cnt <= cnt + U'(1);
    end
  end

`ifdef PWL_LOADER_CKSUM_EN
  localparam int KT = (K_WIDTH < 16) ? K_WIDTH : 16;
  localparam int BT = (B_WIDTH < 16) ? B_WIDTH : 16;
  localparam int CT = (DW < 16) ? DW : 16;

  logic [15:0] sum;
  logic [15:0] k16, b16, c16;
  logic        err;

  assign k16 = 16'(in_data[KT-1:0]);
  assign b16 = 16'(in_data[BT-1:0]);
  assign c16 = 16'(in_data[CT-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      sum <= '0;
      err <= 1'b0;
    end else if (start_ok) begin
      sum <= '0;
      err <= 1'b0;
    end else if (xfer) begin
      case (state)
        GET_K:   sum <= sum + k16;
        GET_B:   sum <= sum + b16;
        CHECK:   err <= (c16 != sum);
        default: sum <= sum;
      endcase
    end
  end

  assign cksum_err = err;
`else
  assign cksum_err = 1'b0;
`endif

endmodule

// File: tb/tb_pwl_coef_loader.sv
// tb/tb_pwl_coef_loader.sv - randomized self-checking bench for pwl_coef_loader (U=2).
// Checksum phase is exercised when built with `define PWL_LOADER_CKSUM_EN.
module tb_pwl_coef_loader;

  localparam int U = 2;
  localparam int N = 1 << U;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, wr_en, busy, done, cksum_err;
  logic [U-1:0] wr_addr;
  logic [31:0] wr_data;

  pwl_coef_loader #(.U(U), .K_WIDTH(16), .B_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .cksum_err(cksum_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int wr_cyc[$];
  logic [31:0] wr_log[$];
  logic [33:0] exp_q[$];
  logic [15:0] kv[N];
  logic [15:0] bv[N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at cycle %0d", nm, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // compare process: every write must match the head of the expected queue
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wr_en", 64'(wr_addr), 64'hFFFF);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(e[33:32]));
        chk("wr_data", 64'(wr_data), 64'(e[31:0]));
      end
      wr_cnt = wr_cnt + 1;
      wr_cyc.push_back(cyc);
      wr_log.push_back(wr_data);
    end
    if (in_ready === 1'b1 && busy !== 1'b1) chk("ready_implies_busy", 64'(busy), 64'd1);
    if (done === 1'b1 && busy !== 1'b0) chk("done_excludes_busy", 64'(busy), 64'd0);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data = w;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (in_ready !== 1'b1) chk("accept_timeout", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  function automatic int pick_gap(input int mode);
    if (mode >= 0) return mode;
    return int'($urandom_range(0, 3));
  endfunction

  // full load; restart_mid pulses start after the first entry's words
  task automatic run_load(input int gap_mode, input bit restart_mid, input logic [15:0] cw,
                          output logic [15:0] model_sum);
    int base, n;
    int s;
    base = wr_cnt;
    s = 0;
    for (int i = 0; i < N; i++) begin
      exp_q.push_back({2'(i), kv[i], bv[i]});
      s = (s + int'(kv[i]) + int'(bv[i])) % 65536;
    end
    model_sum = 16'(s);
    pulse_start();
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("done_cleared", 64'(done), 64'd0);
    chk("cksum_err_cleared", 64'(cksum_err), 64'd0);
    for (int i = 0; i < N; i++) begin
      send_word(kv[i], pick_gap(gap_mode));
      send_word(bv[i], pick_gap(gap_mode));
      if (restart_mid && i == 0) pulse_start();
    end
`ifdef PWL_LOADER_CKSUM_EN
    send_word(cw, pick_gap(gap_mode));
`endif
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("done_after_load", 64'(done), 64'd1);
    chk("busy_after_load", 64'(busy), 64'd0);
    chk("writes_per_load", 64'(wr_cnt - base), 64'(N));
    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
`ifdef PWL_LOADER_CKSUM_EN
    chk("cksum_err", 64'(cksum_err), 64'(cw != model_sum));
`else
    chk("cksum_err_tied", 64'(cksum_err), 64'd0);
`endif
    tick();
    chk("done_held", 64'(done), 64'd1);
  endtask

  initial begin
    logic [15:0] msum;
    int base, n;

    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_cksum_err", 64'(cksum_err), 64'd0);
    rst = 1'b0;
    tick();

    // directed stream, in_valid always high, pinned to literal data and spacing
    for (int i = 0; i < N; i++) begin
      kv[i] = 16'(i + 1);
      bv[i] = 16'((i + 1) * 16);
    end
    base = wr_log.size();
    run_load(0, 1'b0, 16'h00AA, msum);
    chk("lit_sum", 64'(msum), 64'h00AA);
    chk("lit_wr0", 64'(wr_log[base + 0]), 64'h00010010);
    chk("lit_wr1", 64'(wr_log[base + 1]), 64'h00020020);
    chk("lit_wr2", 64'(wr_log[base + 2]), 64'h00030030);
    chk("lit_wr3", 64'(wr_log[base + 3]), 64'h00040040);
    for (int i = 1; i < N; i++)
      chk("wr_spacing", 64'(wr_cyc[base + i] - wr_cyc[base + i - 1]), 64'd3);

`ifdef PWL_LOADER_CKSUM_EN
    run_load(0, 1'b0, 16'h00AB, msum);
    chk("lit_cksum_bad", 64'(cksum_err), 64'd1);
`endif

    // same stream with two idle cycles before every word
    run_load(2, 1'b0, 16'h00AA, msum);

    // start pulsed while busy is ignored
    run_load(0, 1'b1, 16'h00AA, msum);

    // rst after the second write abandons the load
    base = wr_cnt;
    for (int i = 0; i < 2; i++) exp_q.push_back({2'(i), kv[i], bv[i]});
    pulse_start();
    for (int i = 0; i < 2; i++) begin
      send_word(kv[i], 0);
      send_word(bv[i], 0);
    end
    n = 0;
    while (wr_cnt < base + 2 && n < 20) begin
      tick();
      n++;
    end
    chk("writes_before_rst", 64'(wr_cnt - base), 64'd2);
    rst = 1'b1;
    start = 1'b1;
    in_valid = 1'b1;
    tick();
    start = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    repeat (10) tick();
    in_valid = 1'b0;
    chk("no_writes_after_rst", 64'(wr_cnt - base), 64'd2);
    chk("idle_after_rst", 64'(busy), 64'd0);

    // randomized loads; each must restart at address 0
    for (int t = 0; t < 8; t++) begin
      logic [15:0] cw;
      for (int i = 0; i < N; i++) begin
        kv[i] = 16'($urandom);
        bv[i] = 16'($urandom);
      end
      cw = 16'($urandom);
      if (t % 2 == 0) begin
        int s;
        s = 0;
        for (int i = 0; i < N; i++) s = (s + int'(kv[i]) + int'(bv[i])) % 65536;
        cw = 16'(s);
      end
      run_load(-1, ($urandom_range(0, 3) == 0), cw, msum);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
